// File: rtl/zpu_irq_ctrl.sv
// zpu_irq_ctrl: edge-latched, fixed-priority interrupt controller feeding the pipelined ZPU core.
// Optional macro ZPU_IRQ_SYNC_EN inserts a two-flop synchronizer on irq_in (asynchronous sources).
module zpu_irq_ctrl #(
  parameter int                     num_irq         = 8,
  parameter int                     pc_bit_size     = 25,
  parameter logic [pc_bit_size-1:0] vector_base_rst = 25'h0000020
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [num_irq-1:0]     irq_in,
  output logic                   cpu_irq,
  output logic [pc_bit_size-1:0] interuptadr,
  input  logic                   interrutack,
  input  logic                   exitint,
  input  logic [1:0]             reg_adr,
  input  logic                   reg_we,
  input  logic [31:0]            reg_wdat,
  output logic [31:0]            reg_rdat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [num_irq-1:0]     s_w, edge_w, prev_q;
  logic [num_irq-1:0]     pending_q, pending_d;
  logic [num_irq-1:0]     mask_q, mask_d;
  logic [num_irq-1:0]     sw_clr_w, ack_clr_w, active_w;
  logic [pc_bit_size-1:0] vbase_q, vbase_d;
  logic [pc_bit_size-1:0] adr_q, adr_d, vector_w;
  logic [4:0]             idx_w, idx_q, idx_d;
  logic                   irq_q, irq_d;
  logic [31:0]            rdat_q, rdat_d;
  logic                   wr_mask_w, wr_pend_w, wr_vbase_w;
  logic                   unused_w;

`ifdef ZPU_IRQ_SYNC_EN
  logic [num_irq-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign s_w = sync2_q;
`else
  assign s_w = irq_in;
`endif

  assign edge_w     = s_w & ~prev_q;
  assign wr_mask_w  = reg_we && (reg_adr == 2'd0);
  assign wr_pend_w  = reg_we && (reg_adr == 2'd1);
  assign wr_vbase_w = reg_we && (reg_adr == 2'd2);
  assign unused_w   = &{1'b0, reg_wdat};

  assign mask_d   = wr_mask_w  ? reg_wdat[num_irq-1:0]     : mask_q;
  assign vbase_d  = wr_vbase_w ? reg_wdat[pc_bit_size-1:0] : vbase_q;
  assign sw_clr_w = wr_pend_w  ? reg_wdat[num_irq-1:0]     : '0;

  // Acknowledge clears only the committed source, and only while a request is outstanding.
  for (genvar gi = 0; gi < num_irq; gi++) begin : g_ack
    assign ack_clr_w[gi] = (state_q == ST_REQ) && interrutack && (idx_q == 5'(gi));
  end

  // A fresh edge wins over both clears in the same cycle.
  assign pending_d = (pending_q & ~sw_clr_w & ~ack_clr_w) | edge_w;
  assign active_w  = pending_q & mask_q;

  always_comb begin
    idx_w = '0;
    for (int i = num_irq - 1; i >= 0; i--) begin
      if (active_w[i]) idx_w = 5'(i);
    end
  end

  assign vector_w = vbase_q + pc_bit_size'({idx_w, 5'b00000});

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    adr_d   = adr_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (|active_w) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          adr_d   = vector_w;
          idx_d   = idx_w;
        end
      end
      ST_REQ: begin
        if (interrutack) begin
          state_d = ST_SVC;
          irq_d   = 1'b0;
        end
      end
      ST_SVC: begin
        if (exitint) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    rdat_d = '0;
    case (reg_adr)
      2'd0: rdat_d[num_irq-1:0]     = mask_q;
      2'd1: rdat_d[num_irq-1:0]     = pending_q;
      2'd2: rdat_d[pc_bit_size-1:0] = vbase_q;
      default: begin
        rdat_d[31]  = (state_q != ST_IDLE);
        rdat_d[30]  = (state_q == ST_REQ);
        rdat_d[4:0] = (state_q != ST_IDLE) ? idx_q : 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      vbase_q   <= vector_base_rst;
      adr_q     <= '0;
      idx_q     <= '0;
      irq_q     <= 1'b0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= s_w;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      vbase_q   <= vbase_d;
      adr_q     <= adr_d;
      idx_q     <= idx_d;
      irq_q     <= irq_d;
      rdat_q    <= rdat_d;
    end
  end

  assign cpu_irq     = irq_q;
  assign interuptadr = adr_q;
  assign reg_rdat    = rdat_q;

endmodule

// File: doc/zpu_irq_ctrl.md
# zpu_irq_ctrl

Interrupt controller that sits directly upstream of the pipelined ZPU core's interrupt inputs. Collects up to 32 external interrupt lines, latches rising edges into pending bits, masks them and picks the lowest-numbered active source by fixed priority. It drives `cpu_irq` and `interuptadr`, and tracks the in-service source through the core's `interrutack`/`exitint` pair. A small synchronous register port gives software access to mask, pending, vector base and status.

## Interface
- `num_irq`, 8: number of interrupt sources, 1..32.
- `pc_bit_size`, 25: width of the vector address; matches the core.
- `vector_base_rst`, 25'h0000020: reset value of the vector base register.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `irq_in` in num_irq: raw interrupt lines; a rising edge requests service.
- `cpu_irq` out 1: interrupt request to the core; registered.
- `interuptadr` out pc_bit_size: vector address of the requested source; registered.
- `interrutack` in 1: the core accepts the request; one-cycle pulse.
- `exitint` in 1: the core leaves the interrupt routine; one-cycle pulse.
- `reg_adr` in 2: register select.
- `reg_we` in 1: register write strobe.
- `reg_wdat` in 32: register write data.
- `reg_rdat` out 32: register read data; registered.

## Operation
- Registers:
  - 0 MASK: RW, bits [num_irq-1:0]; reset 0.
  - 1 PENDING: read gives pending; writing 1 to a bit clears it; reset 0.
  - 2 VBASE: RW, bits [pc_bit_size-1:0]; reset `vector_base_rst`.
  - 3 STATUS: RO. Bit31 = state!=IDLE, bit30 = state==REQ, bits[4:0] = committed index.
- Unused register bits read 0 and ignore writes.
- Edge detect: `edge[i] = s[i] & ~prev[i]`, where `s` is the (optionally synchronized) `irq_in` and `prev` is `s` delayed one cycle. `prev` resets to 0.
- Pending update each cycle:
  - the bit is set by `edge`;
  - it is cleared by a software W1C or by an acknowledge of that index;
  - set wins over both clears in the same cycle.
- Selection: `active = pending & MASK`. `idx` is the lowest set bit of `active`.
- Vector: `VBASE + (idx << 5)`, truncated to pc_bit_size bits, wrapping modulo 2^pc_bit_size.
- State machine:
  - IDLE: if `active != 0`, register `idx` and the vector, set `cpu_irq=1` and go to REQ.
  - REQ: index and address stay frozen and are committed. A software clear or mask of that source does not withdraw the request. On `interrutack`: `cpu_irq=0`, clear `pending[idx]`, go to SVC.
  - SVC: no new request is raised. On `exitint` go to IDLE; the next request can rise the following cycle.
- Ignored events: `interrutack` outside REQ, and `exitint` outside SVC.
- No nesting. Edges that arrive during REQ/SVC are held in pending.
- Reset, including mid-operation, forces IDLE, `cpu_irq=0`, `interuptadr=0`, `reg_rdat=0`, pending=0, MASK=0, VBASE=`vector_base_rst`.

## Timing
- Without `IRQ_SYNC_EN`, for `irq_in[i]` 0→1 sampled at edge k:
  - `pending[i]=1` after edge k;
  - `cpu_irq=1` and `interuptadr` valid after edge k+1, when MASK allows and state is IDLE.
- With `IRQ_SYNC_EN`: the same events land after edges k+2 and k+3.
- `interrutack` sampled at edge m gives `cpu_irq=0` after edge m and state SVC.
- `exitint` at edge n gives IDLE after edge n. A still-active source raises `cpu_irq` again after edge n+1.
- Register write takes effect after the strobe edge.
- `reg_rdat` reflects `reg_adr` sampled one edge earlier, and shows register values from before that edge.

## Configuration
- `ZPU_IRQ_SYNC_EN` defined: `irq_in` passes through a two-flop synchronizer (reset 0) before edge detect. Adds 2 cycles of latency. Use for asynchronous sources.
- `ZPU_IRQ_SYNC_EN` undefined: `irq_in` feeds edge detect directly. The sources must be synchronous to `clk`.

## Test plan
- Basic request:
  - Stimulus: MASK=8'h04, VBASE=25'h20, pulse `irq_in[2]`.
  - Response: `cpu_irq=1` and `interuptadr=25'h60` one cycle after pending sets. Ack drops `cpu_irq`, PENDING=0 and STATUS bit31=1. `exitint` brings STATUS to 0.
- Priority:
  - Stimulus: MASK=8'hFF, edges on bits 5 and 1 in the same cycle.
  - Response: first vector is `VBASE+0x20`, for index 1. After ack and `exitint`, the next request is index 5 at `VBASE+0xA0`. No request is raised during SVC.
- Masking and W1C:
  - Stimulus: edge on bit 3 with MASK=0.
  - Response: PENDING=8'h08 and `cpu_irq` stays 0. Setting MASK bit 3 raises `cpu_irq` the next cycle. A W1C of bit 3 that coincides with a new edge on bit 3 leaves the bit set.
- Commitment and wrap:
  - Stimulus: software clears pending while in REQ.
  - Response: `cpu_irq` stays 1 until ack.
  - Stimulus: VBASE=25'h1FFFFF0, index 1.
  - Response: `interuptadr=25'h0000010`.
- Reset mid-operation:
  - Stimulus: deassert-asserted `rst` (drive it low) while in SVC.
  - Response: `cpu_irq=0`, `interuptadr=0`, MASK=0, PENDING=0 and STATUS=0 immediately, without waiting for a clock.
- Latency with `ZPU_IRQ_SYNC_EN`: the same stimulus as the basic request gives `cpu_irq` exactly 2 cycles later than without the macro.
